// File: rtl/pool_pkg.sv
// Shared constants and helpers for the 2x2 stride-2 pooling engine.
package pool_pkg;

  // Per-frame reduction select, latched on the first pixel of a frame.
  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  // Row-parity phase; the phase register is row[0] itself.
  localparam logic PH_EVEN_ROW = 1'b0;
  localparam logic PH_ODD_ROW  = 1'b1;

  // Ceil(log2(value)), never less than 1 so counters always have a bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    if (result == 0) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// Flop-based line buffer holding one partial per horizontal pixel pair of an even row.
module pool_line_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 33,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage is always written on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_pool2x2.sv
// Streaming 2x2 / stride-2 max or average pooling over a raster-order pixel stream.
module stream_pool2x2
  import pool_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FRAC_BITS = 30,
  parameter int unsigned IMG_W     = 8,
  parameter int unsigned IMG_H     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  localparam int unsigned CW       = clog2(IMG_W);
  localparam int unsigned RW       = clog2(IMG_H);
  localparam int unsigned LB_DEPTH = IMG_W / 2;
  localparam int unsigned LB_AW    = clog2(LB_DEPTH);

  if ((IMG_W < 2) || ((IMG_W % 2) != 0)) begin : g_bad_img_w
    $error("stream_pool2x2: IMG_W must be even and >= 2");
  end
  if ((IMG_H < 2) || ((IMG_H % 2) != 0)) begin : g_bad_img_h
    $error("stream_pool2x2: IMG_H must be even and >= 2");
  end
  if (FRAC_BITS > WIDTH) begin : g_bad_frac
    $error("stream_pool2x2: FRAC_BITS cannot exceed WIDTH");
  end

  logic [CW-1:0]    col_q;
  logic [RW-1:0]    row_q;
  logic             mode_q;
  logic [WIDTH-1:0] hold_q;

  logic             phase;
  logic             col_odd;
  logic             col_last;
  logic             row_last;
  logic             emit_pos;
  logic             accept;

  logic             lb_we;
  logic [LB_AW-1:0] lb_addr;
  logic [WIDTH:0]   lb_wdata;
  logic [WIDTH:0]   lb_rdata;

  logic [WIDTH-1:0] pair_max;
  logic [WIDTH+1:0] win_sum;
  logic [WIDTH-1:0] win_result;

  assign phase    = row_q[0];
  assign col_odd  = col_q[0];
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign emit_pos = col_odd & (phase == PH_ODD_ROW);

  // Only an emit beat facing a full, unread output register is stalled.
  assign in_ready = ~(emit_pos & out_valid & ~out_ready);
  assign accept   = in_valid & in_ready;

  assign lb_we   = accept & col_odd & (phase == PH_EVEN_ROW);
  assign lb_addr = LB_AW'(col_q >> 1);

  // Pair reduction for the even row, and the 2x2 window reduction for the odd row.
  always_comb begin
    pair_max   = (hold_q > in_data) ? hold_q : in_data;
    lb_wdata   = {1'b0, pair_max};
    win_sum    = {1'b0, lb_rdata} + {2'b00, hold_q} + {2'b00, in_data};
    win_result = (lb_rdata[WIDTH-1:0] > pair_max) ? lb_rdata[WIDTH-1:0] : pair_max;
    if (mode_q == POOL_AVG) begin
      lb_wdata   = {1'b0, hold_q} + {1'b0, in_data};
      win_result = win_sum[WIDTH+1:2];
    end
  end

  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .DW    (WIDTH + 1),
    .AW    (LB_AW)
  ) u_line_buffer (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (lb_wdata),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // Raster position counters; row[0] doubles as the even/odd row phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Frame mode latch and even-column pixel hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= POOL_MAX;
      hold_q <= '0;
    end else if (accept) begin
      if ((col_q == '0) && (row_q == '0)) begin
        mode_q <= mode;
      end
      if (!col_odd) begin
        hold_q <= in_data;
      end
    end
  end

  // Single-entry output register; a reload in the drain cycle keeps it valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept && emit_pos) begin
      out_valid <= 1'b1;
      out_data  <= win_result;
      out_last  <= row_last & col_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_pool2x2.sv
// Scoreboard bench for stream_pool2x2: a frame-level model pushes expected windows,
// a monitor pops and compares on every output handshake.
module tb_stream_pool2x2;

  localparam int IW   = 8;
  localparam int IH   = 8;
  localparam int NPIX = IW * IH;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;

  int n_checks = 0;
  int n_fail   = 0;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  logic [31:0] exp_data_q[$];
  logic        exp_last_q[$];
  logic [31:0] pix[NPIX];

  always #5 clk = ~clk;

  stream_pool2x2 #(
    .WIDTH     (32),
    .FRAC_BITS (30),
    .IMG_W     (IW),
    .IMG_H     (IH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Downstream readiness pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: every output handshake is matched against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] d;
    logic        l;
    if (rst_n && out_valid && out_ready) begin
      if (exp_data_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, expected none", out_data);
      end else begin
        d = exp_data_q.pop_front();
        l = exp_last_q.pop_front();
        check("out_data", {32'h0, out_data}, {32'h0, d});
        check("out_last", {63'h0, out_last}, {63'h0, l});
      end
    end
  end

  // Reference: each 2x2 window computed directly from the frame image.
  task automatic push_expected(input logic m);
    longint unsigned a, b, c, d, mx, avg;
    for (int r = 0; r < IH / 2; r++) begin
      for (int k = 0; k < IW / 2; k++) begin
        a = longint'(pix[(2 * r) * IW + 2 * k]);
        b = longint'(pix[(2 * r) * IW + 2 * k + 1]);
        c = longint'(pix[(2 * r + 1) * IW + 2 * k]);
        d = longint'(pix[(2 * r + 1) * IW + 2 * k + 1]);
        mx = a;
        if (b > mx) mx = b;
        if (c > mx) mx = c;
        if (d > mx) mx = d;
        avg = (a + b + c + d) / 4;
        exp_data_q.push_back(m ? avg[31:0] : mx[31:0]);
        exp_last_q.push_back((r == IH / 2 - 1) && (k == IW / 2 - 1));
      end
    end
  endtask

  task automatic send_pixel(input logic [31:0] d, input logic m, output int stalls);
    in_data  = d;
    mode     = m;
    in_valid = 1'b1;
    stalls   = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 200) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_timeout: got stalled %0d cycles, expected accept", stalls);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_range(input logic m, input bit toggle, input int gap_max,
                             input int lo, input int hi);
    int st;
    logic pm;
    for (int i = lo; i < hi; i++) begin
      pm = (i == 0 || !toggle) ? m : 1'($urandom_range(0, 1));
      send_pixel(pix[i], pm, st);
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic randomize_frame();
    for (int i = 0; i < NPIX; i++) pix[i] = $urandom;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_data_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (exp_data_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outputs pending, expected 0", exp_data_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int st;
    logic m;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {63'h0, out_valid}, 64'h0);
    check("reset_out_data", {32'h0, out_data}, 64'h0);
    check("reset_out_last", {63'h0, out_last}, 64'h0);
    check("reset_in_ready", {63'h0, in_ready}, 64'h1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Average frame carrying the directed single-window vectors
    ready_mode = 1;
    randomize_frame();
    pix[0]  = 32'h4000_0000; pix[1]  = 32'h2000_0000;
    pix[8]  = 32'h1000_0000; pix[9]  = 32'h1000_0000;
    pix[2]  = 32'hFFFF_FFFF; pix[3]  = 32'hFFFF_FFFF;
    pix[10] = 32'hFFFF_FFFF; pix[11] = 32'hFFFF_FFFF;
    pix[4]  = 32'h1;         pix[5]  = 32'h1;
    pix[12] = 32'h1;         pix[13] = 32'h0;
    push_expected(1'b1);
    drive_range(1'b1, 1'b0, 0, 0, 10);
    check("latency_valid", {63'h0, out_valid}, 64'h1);
    check("latency_data", {32'h0, out_data}, 64'h2000_0000);
    drive_range(1'b1, 1'b0, 0, 10, NPIX);
    wait_drain();

    // Max frame with the directed max window
    ready_mode = 2;
    randomize_frame();
    pix[0] = 32'h1; pix[1] = 32'hFFFF_FFFF; pix[8] = 32'h0; pix[9] = 32'h8000_0000;
    push_expected(1'b0);
    drive_range(1'b0, 1'b0, 2, 0, NPIX);

    // Ramp frame, then a random frame with no bubble at the boundary
    for (int i = 0; i < NPIX; i++) pix[i] = i;
    push_expected(1'b1);
    ready_mode = 1;
    drive_range(1'b1, 1'b0, 0, 0, NPIX);
    randomize_frame();
    push_expected(1'b0);
    drive_range(1'b0, 1'b0, 0, 0, NPIX);
    wait_drain();

    // Backpressure: only the second emit beat may stall
    ready_mode = 0;
    out_ready  = 1'b0;
    randomize_frame();
    push_expected(1'b1);
    for (int i = 0; i < 11; i++) begin
      send_pixel(pix[i], 1'b1, st);
      check("no_stall_before_second_emit", 64'(st), 64'h0);
    end
    in_data  = pix[11];
    in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_on_emit", {63'h0, in_ready}, 64'h0);
    end
    ready_mode = 2;
    drive_range(1'b1, 1'b0, 1, 11, NPIX);
    wait_drain();

    // Reset mid-frame after 5 pixels, then a clean frame
    randomize_frame();
    drive_range(1'b1, 1'b0, 0, 0, 5);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midreset_out_valid", {63'h0, out_valid}, 64'h0);
    check("midreset_in_ready", {63'h0, in_ready}, 64'h1);
    rst_n = 1'b1;
    randomize_frame();
    push_expected(1'b0);
    drive_range(1'b0, 1'b0, 1, 0, NPIX);

    // Mode toggled mid-frame must not matter
    randomize_frame();
    push_expected(1'b1);
    drive_range(1'b1, 1'b1, 1, 0, NPIX);
    randomize_frame();
    push_expected(1'b0);
    drive_range(1'b0, 1'b1, 1, 0, NPIX);

    // Random frames
    for (int f = 0; f < 3; f++) begin
      m = 1'($urandom_range(0, 1));
      randomize_frame();
      push_expected(m);
      drive_range(m, 1'b1, 2, 0, NPIX);
    end
    wait_drain();
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
